// File: rtl/uno_pe_pkg.sv
// -----------------------------------------------------------------------------
// uno_pe_pkg
// Types and constants shared by the PE operand normalisation stage and its
// return-path partner (uno_result_denorm / uno_tag_fifo).
//   uno_op_e   : gemm_uno operation code carried with every operand tag
//   uno_tag_t  : per-issue tag {mode, leading-one position}
//   EXP_BIAS   : fraction width of the operand format; the exponent of a tag
//                is its leading-one position minus this bias
// -----------------------------------------------------------------------------
package uno_pe_pkg;

    localparam int UNO_FRA_BW = 10;
    localparam int EXP_BIAS   = UNO_FRA_BW;

    typedef enum logic [1:0] {
        GEMM = 2'b00,
        DIV  = 2'b01,
        EXP  = 2'b10,
        LOG  = 2'b11
    } uno_op_e;

    typedef struct packed {
        uno_op_e    mode;
        logic [4:0] pos;
    } uno_tag_t;

endpackage

// File: rtl/uno_tag_fifo.sv
// -----------------------------------------------------------------------------
// uno_tag_fifo
// Synchronous DEPTH-entry FIFO of operand tags. The head entry is visible
// combinationally so it can be paired with an accumulator result in the same
// cycle the result is accepted.
// Ports:
//   clk, rst          clock, synchronous active-high reset (flushes FIFO)
//   push_valid_i      push request; push happens when push_ready_o is high
//   push_ready_o      FIFO not full
//   push_data_i       tag to store
//   pop_i             pop strobe (ignored while empty)
//   head_o            oldest stored tag
//   count_o           number of stored tags (0..DEPTH)
//   full_o, empty_o   occupancy flags derived from the registered count
// -----------------------------------------------------------------------------
module uno_tag_fifo
    import uno_pe_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_valid_i,
    output logic          push_ready_o,
    input  uno_tag_t      push_data_i,
    input  logic          pop_i,
    output uno_tag_t      head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    uno_tag_t      mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    assign full_o       = (count_q == CW'(DEPTH));
    assign empty_o      = (count_q == '0);
    assign push_ready_o = !full_o;
    assign count_o      = count_q;
    assign head_o       = mem_q[rd_ptr_q];

    // Fullness is taken from registered state only, so a pop while full
    // frees the slot for the following cycle, never the current one.
    assign push = push_valid_i && !full_o;
    assign pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: an entry is only read after it was written.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == PW'(gi))) begin
                mem_q[gi] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/uno_result_denorm.sv
// -----------------------------------------------------------------------------
// uno_result_denorm
// Return path of the PE operand normalisation stage. Tags recorded at issue
// (operation mode + operand leading-one position) are queued in order; each
// accumulator result is paired with the oldest tag and rescaled by a signed
// power of two (div: 2^-e, exp: 2^e, e = pos - FRA_BW) or passed through
// (gemm, log). Left shifts saturate to the signed range of ACC_BW; right
// shifts are arithmetic and truncate toward -inf. One-cycle latency into a
// holding output register with valid/ready handshake.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   tag_valid_i    tag push request        tag_ready_o  tag FIFO not full
//   tag_mode_i     gemm_uno code           tag_pos_i    leading-one index
//   acc_valid_i    result valid            acc_ready_o  result accepted
//   acc_i          accumulator result (signed)
//   out_valid_o    output valid            out_ready_i  downstream accept
//   out_o          denormalised result (signed)
// Optional (macro UNO_DENORM_STATUS_EN):
//   sat_o          current output was clamped
//   sat_cnt_o      saturating count of clamped accepts
// -----------------------------------------------------------------------------
module uno_result_denorm
    import uno_pe_pkg::*;
#(
    parameter int INT_BW = 5,
    parameter int FRA_BW = EXP_BIAS,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tag_valid_i,
    output logic                     tag_ready_o,
    input  logic [1:0]               tag_mode_i,
    input  logic [4:0]               tag_pos_i,
    input  logic                     acc_valid_i,
    output logic                     acc_ready_o,
    input  logic signed [ACC_BW-1:0] acc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [ACC_BW-1:0] out_o
`ifdef UNO_DENORM_STATUS_EN
    ,
    output logic                     sat_o,
    output logic [15:0]              sat_cnt_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    // Largest meaningful leading-one index; keeps a stray position from
    // producing an exponent outside the operand format.
    localparam int POS_MAX = (MUL_BW - 1 < INT_BW + FRA_BW) ? (MUL_BW - 1) : (INT_BW + FRA_BW);
    // Wide enough to hold any left shift without losing overflow bits.
    localparam int XW = ACC_BW + 32;
    localparam logic signed [XW-1:0] SAT_MAX_X = {{(XW-ACC_BW+1){1'b0}}, {(ACC_BW-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_MIN_X = {{(XW-ACC_BW+1){1'b1}}, {(ACC_BW-1){1'b0}}};
    localparam logic signed [ACC_BW-1:0] OUT_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] OUT_MIN = {1'b1, {(ACC_BW-1){1'b0}}};

    uno_tag_t      push_tag;
    uno_tag_t      head_tag;
    logic          fifo_ready;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          unused_fifo;

    logic                     accept;
    logic                     out_valid_q, out_valid_d;
    logic signed [ACC_BW-1:0] out_q, out_d;

    int                       pos_int;
    int                       exp_int;
    int                       shamt;
    int                       shamt_neg;
    logic [5:0]               lsh;
    logic [5:0]               rsh;
    logic signed [XW-1:0]     acc_x;
    logic signed [XW-1:0]     shl_x;
    logic signed [ACC_BW-1:0] res;
    logic                     res_sat;

    assign push_tag.mode = uno_op_e'(tag_mode_i);
    assign push_tag.pos  = tag_pos_i;

    uno_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (tag_valid_i),
        .push_ready_o (fifo_ready),
        .push_data_i  (push_tag),
        .pop_i        (accept),
        .head_o       (head_tag),
        .count_o      (fifo_count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    // Occupancy count is informational here; the flags carry the decisions.
    assign unused_fifo = ^{fifo_count, fifo_full};

    // Both ready outputs are held low while rst is asserted so nothing is
    // exchanged with a block that is being flushed.
    assign tag_ready_o = !rst && fifo_ready;
    assign acc_ready_o = !rst && !fifo_empty && (!out_valid_q || out_ready_i);
    assign accept      = acc_valid_i && acc_ready_o;

    // Rescale of the incoming result against the head tag.
    // shamt > 0 means multiply by 2^shamt, shamt < 0 means divide.
    always_comb begin
        pos_int = int'(head_tag.pos);
        if (pos_int > POS_MAX) begin
            pos_int = POS_MAX;
        end
        exp_int = pos_int - FRA_BW;

        case (head_tag.mode)
            DIV:     shamt = -exp_int;
            EXP:     shamt = exp_int;
            default: shamt = 0;
        endcase

        shamt_neg = -shamt;
        acc_x     = {{(XW-ACC_BW){acc_i[ACC_BW-1]}}, acc_i};
        lsh       = '0;
        rsh       = '0;
        shl_x     = '0;
        res       = acc_i;
        res_sat   = 1'b0;

        if (shamt > 0) begin
            lsh   = shamt[5:0];
            shl_x = acc_x <<< lsh;
            if (shl_x > SAT_MAX_X) begin
                res     = OUT_MAX;
                res_sat = 1'b1;
            end else if (shl_x < SAT_MIN_X) begin
                res     = OUT_MIN;
                res_sat = 1'b1;
            end else begin
                res = shl_x[ACC_BW-1:0];
            end
        end else if (shamt < 0) begin
            rsh = shamt_neg[5:0];
            res = acc_i >>> rsh;
        end
    end

    // Output register: loads on accept, holds while stalled, clears its
    // valid once the downstream takes the value.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_d       = res;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_o       = out_q;

`ifdef UNO_DENORM_STATUS_EN
    logic        sat_q, sat_d;
    logic [15:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_d     = sat_q;
        sat_cnt_d = sat_cnt_q;
        if (accept) begin
            sat_d = res_sat;
            if (res_sat && (sat_cnt_q != 16'hFFFF)) begin
                sat_cnt_d = sat_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q     <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            sat_q     <= sat_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_o     = sat_q;
    assign sat_cnt_o = sat_cnt_q;
`else
    logic unused_sat;
    assign unused_sat = res_sat;
`endif

endmodule

// File: tb/tb_uno_result_denorm.sv
// -----------------------------------------------------------------------------
// tb_uno_result_denorm
// Directed vectors with hand-computed results. Expected outputs are queued
// when a result is accepted; a forked monitor pops and compares each output
// handshake and checks that a stalled output holds steady.
// -----------------------------------------------------------------------------
module tb_uno_result_denorm;

    logic               clk;
    logic               rst;
    logic               tag_valid_i;
    logic               tag_ready_o;
    logic [1:0]         tag_mode_i;
    logic [4:0]         tag_pos_i;
    logic               acc_valid_i;
    logic               acc_ready_o;
    logic signed [31:0] acc_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic signed [31:0] out_o;
`ifdef UNO_DENORM_STATUS_EN
    logic               sat_o;
    logic [15:0]        sat_cnt_o;
`endif

    uno_result_denorm #(
        .INT_BW (5),
        .FRA_BW (10),
        .MUL_BW (16),
        .ACC_BW (32),
        .DEPTH  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tag_valid_i (tag_valid_i),
        .tag_ready_o (tag_ready_o),
        .tag_mode_i  (tag_mode_i),
        .tag_pos_i   (tag_pos_i),
        .acc_valid_i (acc_valid_i),
        .acc_ready_o (acc_ready_o),
        .acc_i       (acc_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_o       (out_o)
`ifdef UNO_DENORM_STATUS_EN
        ,
        .sat_o       (sat_o),
        .sat_cnt_o   (sat_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        sat;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_sat_exp = 0;
    int   mon_cyc   = 0;
    int   last_fire = 0;
    int   prev_fire = 0;

    // Directed vectors: mode, pos, acc, expected out, expected saturation.
    localparam int NV = 13;
    logic [1:0]  v_mode [NV] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10, 2'b10,
                                 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
    logic [4:0]  v_pos  [NV] = '{5'd12, 5'd8, 5'd0, 5'd5, 5'd15, 5'd15, 5'd15,
                                 5'd15, 5'd10, 5'd0, 5'd15, 5'd15, 5'd0};
    logic [31:0] v_acc  [NV] = '{32'h0000_1000, 32'hFFFF_F000, 32'h0040_0000, 32'h1234_5678,
                                 32'h8000_0001, 32'hFFFF_FFFF, 32'hF000_0000, 32'hFFFF_FFFF,
                                 32'h0000_0005, 32'h0000_0C00, 32'h03FF_FFFF, 32'h0400_0000,
                                 32'hFFFF_FFFF};
    logic [31:0] v_exp  [NV] = '{32'h0000_0400, 32'hFFFF_FC00, 32'h7FFF_FFFF, 32'h1234_5678,
                                 32'h8000_0001, 32'hFFFF_FFE0, 32'h8000_0000, 32'hFFFF_FFFF,
                                 32'h0000_0005, 32'h0000_0003, 32'h7FFF_FFE0, 32'h7FFF_FFFF,
                                 32'hFFFF_FC00};
    logic        v_sat  [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT (t=%0t)", nm, $time);
    endtask

    task automatic push_tag(input logic [1:0] mode, input logic [4:0] pos);
        bit ok = 0;
        tag_valid_i = 1'b1;
        tag_mode_i  = mode;
        tag_pos_i   = pos;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tag_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout_fail("push_tag");
        @(posedge clk);
        #1;
        tag_valid_i = 1'b0;
        $display("tag push   mode=%b pos=%0d", mode, pos);
    endtask

    // Leaves acc_valid_i high so consecutive calls drive back-to-back accepts.
    task automatic send_acc(input logic [31:0] a, input logic [31:0] e, input logic s, input int id);
        exp_t it;
        bit ok = 0;
        acc_valid_i = 1'b1;
        acc_i       = a;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (acc_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            it.data = e;
            it.sat  = s;
            it.id   = id;
            exp_q.push_back(it);
            if (s) n_sat_exp++;
        end else begin
            timeout_fail("send_acc");
        end
        @(posedge clk);
        #1;
        $display("acc accept id=%0d acc=%h expect=%h", id, a, e);
    endtask

    task automatic acc_idle();
        acc_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t it;
        bit   hold;
        logic [31:0] hold_val;

        rst         = 1'b1;
        tag_valid_i = 1'b0;
        tag_mode_i  = 2'b00;
        tag_pos_i   = 5'd0;
        acc_valid_i = 1'b0;
        acc_i       = '0;
        out_ready_i = 1'b1;

        // Output monitor / scoreboard.
        fork
            begin
                hold     = 0;
                hold_val = '0;
                forever begin
                    @(negedge clk);
                    mon_cyc++;
                    if (rst) begin
                        hold = 0;
                    end else begin
                        if (hold) begin
                            check("hold_out", out_o, hold_val);
                            check("hold_valid", {31'b0, out_valid_o}, 32'd1);
                        end
                        if (out_valid_o && out_ready_i) begin
                            if (exp_q.size() == 0) begin
                                n_checks++;
                                n_fail++;
                                $display("FAIL unexpected_out: got %h, expected no output", out_o);
                            end else begin
                                it = exp_q.pop_front();
                                check("out_data", out_o, it.data);
`ifdef UNO_DENORM_STATUS_EN
                                check("sat_o", {31'b0, sat_o}, {31'b0, it.sat});
`endif
                                prev_fire = last_fire;
                                last_fire = mon_cyc;
                                $display("out id=%0d data=%h", it.id, out_o);
                            end
                        end
                        hold     = out_valid_o && !out_ready_i;
                        hold_val = out_o;
                    end
                end
            end
        join_none

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_tag_ready", {31'b0, tag_ready_o}, 32'd0);
        check("rst_acc_ready", {31'b0, acc_ready_o}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
        check("rst_out", out_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tag_ready", {31'b0, tag_ready_o}, 32'd1);
        @(posedge clk);
        #1;

        // Mode / shift / saturation vectors.
        for (int i = 0; i < NV; i++) begin
            push_tag(v_mode[i], v_pos[i]);
            send_acc(v_acc[i], v_exp[i], v_sat[i], i);
            acc_idle();
        end
        wait_drain();
`ifdef UNO_DENORM_STATUS_EN
        check("sat_cnt", {16'b0, sat_cnt_o}, 32'(n_sat_exp));
`endif

        // Full FIFO: four tags fill it, a fifth is ignored.
        push_tag(2'b00, 5'd3);
        push_tag(2'b01, 5'd11);
        push_tag(2'b10, 5'd11);
        push_tag(2'b11, 5'd2);
        @(negedge clk);
        check("full_tag_ready", {31'b0, tag_ready_o}, 32'd0);
        tag_valid_i = 1'b1;
        tag_mode_i  = 2'b10;
        tag_pos_i   = 5'd15;
        @(posedge clk);
        #1;
        tag_valid_i = 1'b0;
        send_acc(32'h0000_0011, 32'h0000_0011, 1'b0, 100);
        send_acc(32'h0000_0100, 32'h0000_0080, 1'b0, 101);
        send_acc(32'h0000_0100, 32'h0000_0200, 1'b0, 102);
        send_acc(32'h0000_DEAD, 32'h0000_DEAD, 1'b0, 103);
        acc_idle();
        wait_drain();
        @(negedge clk);
        check("empty_after_four", {31'b0, acc_ready_o}, 32'd0);

        // Result presented with an empty FIFO stalls until a tag arrives.
        @(posedge clk);
        #1;
        acc_valid_i = 1'b1;
        acc_i       = 32'h0000_CAFE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("empty_stall", {31'b0, acc_ready_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        push_tag(2'b00, 5'd7);
        send_acc(32'h0000_CAFE, 32'h0000_CAFE, 1'b0, 200);
        acc_idle();
        wait_drain();

        // Backpressure with two tags queued, then back-to-back release.
        out_ready_i = 1'b0;
        push_tag(2'b00, 5'd1);
        push_tag(2'b10, 5'd11);
        send_acc(32'h0000_1234, 32'h0000_1234, 1'b0, 300);
        acc_i = 32'h0000_0040;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_acc_ready", {31'b0, acc_ready_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready_i = 1'b1;
        send_acc(32'h0000_0040, 32'h0000_0080, 1'b0, 301);
        acc_idle();
        wait_drain();
        check("back_to_back_gap", 32'(last_fire - prev_fire), 32'd1);

        // Reset mid-stream: three tags queued and a result held.
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push_tag(2'b10, 5'd15);
        send_acc(32'h0000_0080, 32'h0000_1000, 1'b0, 400);
        acc_idle();
        @(negedge clk);
        check("pre_rst_valid", {31'b0, out_valid_o}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {31'b0, out_valid_o}, 32'd0);
        check("midrst_tag_ready", {31'b0, tag_ready_o}, 32'd1);
        check("midrst_flushed", {31'b0, acc_ready_o}, 32'd0);
        @(posedge clk);
        #1;
        out_ready_i = 1'b1;
        push_tag(2'b01, 5'd13);
        send_acc(32'h0000_0080, 32'h0000_0010, 1'b0, 401);
        acc_idle();
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uno_result_denorm.md
Name: uno_result_denorm

Overview:
- Return-path partner of the PE operand offset/normalisation stage.
- At issue, the operand side records the leading-one position of each operand. This block buffers those tags in order.
- It pairs each tag with the matching accumulator result and undoes the normalisation by a signed power-of-two rescale (div, exp), or passes the result through (gemm, log).
- Sits between the PE accumulator and the PE output register.

Parameters:
- INT_BW, 5, integer bits of operand fixed-point format
- FRA_BW, 10, fraction bits of operand fixed-point format
- MUL_BW, 16, operand width
- ACC_BW, 32, accumulator/result width
- DEPTH, 4, tag FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- tag_valid_i  in  1  tag push request
- tag_ready_o  out  1  tag FIFO not full
- tag_mode_i  in  2  gemm_uno code: 00 gemm, 01 div, 10 exp, 11 log
- tag_pos_i  in  5  leading-one index of operand (0..MUL_BW-1)
- acc_valid_i  in  1  accumulator result valid
- acc_ready_o  out  1  result accepted this cycle
- acc_i  in  ACC_BW signed  accumulator result
- out_valid_o  out  1  denormalised result valid
- out_ready_i  in  1  downstream accept
- out_o  out  ACC_BW signed  denormalised result

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst). All state resets on a clk edge with rst=1.
- Reset values: tag_ready_o=0 while rst=1, and 1 after reset (FIFO empty); acc_ready_o=0; out_valid_o=0; out_o=0; FIFO pointers and count = 0.
- Tag push: occurs when tag_valid_i && tag_ready_o. tag_ready_o = (count != DEPTH).
- acc_ready_o = (count != 0) && (!out_valid_o || out_ready_i). It is combinational from registered state and out_ready_i.
- Accept: acc_valid_i && acc_ready_o pops the head tag and loads the output register. Latency is 1 cycle: out_valid_o is high the following cycle.
- Exponent: e = signed(tag_pos) - FRA_BW, range -10..+5.
- Modes:
  - 00 gemm: out = acc.
  - 01 div: out = acc * 2^-e (arithmetic right shift by e if e>0, left shift by -e if e<0).
  - 10 exp: out = acc * 2^e.
  - 11 log: out = acc (additive offset already applied upstream).
- Left shifts saturate to 0x7FFF...F or 0x800...0 according to the sign of acc. Right shifts are arithmetic and truncating (round toward -inf).
- Output hold: out_o and out_valid_o stay stable while out_valid_o && !out_ready_i.
- Full-throughput case: out_ready_i=1 with a new accept gives back-to-back outputs, one per cycle.
- FIFO empty with acc_valid_i=1: acc_ready_o=0. The block stalls; no result is lost or duplicated.
- FIFO full: tag_ready_o=0 and the push is ignored.
- Simultaneous push and pop when count==DEPTH: the pop frees a slot next cycle only. Full is registered; there is no same-cycle pass-through.
- Simultaneous push and pop when count==0 is impossible: acc_ready_o=0.
- Pointers wrap modulo DEPTH.
- rst mid-operation: the FIFO flushes and out_valid_o drops the next cycle. Any pending result is discarded.

Optional Feature:
- Macro: UNO_DENORM_STATUS_EN.
- When defined:
  - Adds output sat_o (1 bit), registered alongside out_o; high when the current result saturated.
  - Adds output sat_cnt_o (16 bits), which counts saturated accepts, saturates at 0xFFFF and clears on rst.
- When undefined: neither port exists and there is no saturation-detect state. Saturation clamping itself always occurs.

Decomposition:
- Shared package uno_pe_pkg holds:
  - uno_op_e enum (GEMM, DIV, EXP, LOG) for gemm_uno codes.
  - uno_tag_t struct {mode[1:0], pos[4:0]}.
  - Localparam EXP_BIAS = FRA_BW.
- One sub-module: uno_tag_fifo. It is a synchronous DEPTH-entry FIFO of uno_tag_t with valid/ready push, pop strobe, count, full and empty.
- Shift/saturate logic stays inline in uno_result_denorm.

Test Plan (ACC_BW=32, FRA_BW=10, DEPTH=4):
- div: push tag {01, pos=12} (e=2), acc_i=0x0000_1000 -> out_o=0x0000_0400 one cycle after accept.
- exp: push tag {10, pos=8} (e=-2), acc_i=0xFFFF_F000 -> out_o=0xFFFF_FC00 (arithmetic shift).
- Saturation: tag {01, pos=0} (e=-10, left 10), acc_i=0x0040_0000 -> out_o=0x7FFF_FFFF. With UNO_DENORM_STATUS_EN: sat_o=1 and sat_cnt_o increments 0->1.
- Full/empty: push 4 tags -> tag_ready_o=0, 5th push ignored. Present acc_valid_i with an empty FIFO -> acc_ready_o=0 for 3 cycles, then push a gemm tag -> acc accepted, out_o=acc_i.
- Backpressure: out_ready_i=0 for 5 cycles with 2 tags queued -> out_o stable, acc_ready_o=0. Release -> two results in order, back-to-back.
- Reset mid-stream: 3 tags queued and out_valid_o=1, assert rst one cycle -> out_valid_o=0, tag_ready_o=1 after reset, and the next result uses a newly pushed tag.
